fc_hwacc_tcdm_mux: RTL

// - Downstream stage of the FC LSTM accelerator: merges its N TCDM master ports into one TCDM master port toward the SoC interconnect.
// - Round-robin arbitration with a locked grant; every granted request yields exactly one in-order r_valid, routed back to the issuing port via an ID FIFO.

---
 rtl/fc_hwacc_pkg.sv | 29 ++
 rtl/hwacc_id_fifo.sv | 59 +++++
 rtl/fc_hwacc_tcdm_mux.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fc_hwacc_pkg.sv
// rtl/fc_hwacc_pkg.sv - shared configuration, types and helpers for the FC accelerator TCDM mux
// Purpose: single source for the port count, outstanding depth and bus widths,
// plus the request-field bundle and port-index type used by the mux and ID FIFO.
// Ports: none (package).
package fc_hwacc_pkg;

  localparam int N_PORTS_CFG    = 4;
  localparam int MAX_OUTST_CFG  = 4;
  localparam int ADDR_WIDTH_CFG = 32;
  localparam int DATA_WIDTH_CFG = 32;
  localparam int BE_WIDTH       = DATA_WIDTH_CFG / 8;
  localparam int IDX_WIDTH      = $clog2(N_PORTS_CFG);

  typedef logic [IDX_WIDTH-1:0] port_idx_t;

  typedef struct packed {
    logic [ADDR_WIDTH_CFG-1:0] add;
    logic                      wen;
    logic [BE_WIDTH-1:0]       be;
    logic [DATA_WIDTH_CFG-1:0] wdata;
  } tcdm_req_t;

  // Round-robin successor; explicit wrap so non-power-of-2 port counts work.
  function automatic port_idx_t next_idx(port_idx_t idx);
    if (int'(idx) == N_PORTS_CFG - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/hwacc_id_fifo.sv
// rtl/hwacc_id_fifo.sv - in-order FIFO of issuing port indices for outstanding TCDM transactions
// Purpose: remembers which port owns each granted-but-unanswered request so
// responses can be routed back in order.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write;
// pop_i read; head_o oldest entry; full_o/empty_o occupancy flags.
module hwacc_id_fifo
  import fc_hwacc_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_CFG
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  port_idx_t data_i,
  input  logic      pop_i,
  output port_idx_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

  port_idx_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // The caller never pushes when full; gating here keeps the FIFO safe anyway.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fc_hwacc_tcdm_mux.sv
// rtl/fc_hwacc_tcdm_mux.sv - N-to-1 TCDM request mux with locked round-robin and in-order response routing
// Purpose: merges the accelerator's TCDM master ports onto one SoC-side port.
// Ports: clk_i, rst_ni (async, active low);
//   s_req_i/s_gnt_o/s_add_i/s_wen_i/s_be_i/s_wdata_i  per-port request channel (flattened);
//   s_r_rdata_o/s_r_valid_o                         per-port response channel;
//   m_req_o/m_gnt_i/m_add_o/m_wen_o/m_be_o/m_wdata_o  merged request channel;
//   m_r_rdata_i/m_r_valid_i                         merged response channel;
//   err_o  sticky flag: response arrived with nothing outstanding.
module fc_hwacc_tcdm_mux
  import fc_hwacc_pkg::*;
#(
  parameter int N_PORTS    = N_PORTS_CFG,
  parameter int MAX_OUTST  = MAX_OUTST_CFG,
  parameter int ADDR_WIDTH = ADDR_WIDTH_CFG,
  parameter int DATA_WIDTH = DATA_WIDTH_CFG
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_PORTS-1:0]            s_req_i,
  output logic [N_PORTS-1:0]            s_gnt_o,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] s_add_i,
  input  logic [N_PORTS-1:0]            s_wen_i,
  input  logic [N_PORTS*BE_WIDTH-1:0]   s_be_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_wdata_i,
  output logic [N_PORTS*DATA_WIDTH-1:0] s_r_rdata_o,
  output logic [N_PORTS-1:0]            s_r_valid_o,
  output logic                          m_req_o,
  input  logic                          m_gnt_i,
  output logic [ADDR_WIDTH-1:0]         m_add_o,
  output logic                          m_wen_o,
  output logic [BE_WIDTH-1:0]           m_be_o,
  output logic [DATA_WIDTH-1:0]         m_wdata_o,
  input  logic [DATA_WIDTH-1:0]         m_r_rdata_i,
  input  logic                          m_r_valid_i,
  output logic                          err_o
);

  // Port-index and request types come from the package, so the instance must match it.
  if (N_PORTS != N_PORTS_CFG || MAX_OUTST != MAX_OUTST_CFG ||
      ADDR_WIDTH != ADDR_WIDTH_CFG || DATA_WIDTH != DATA_WIDTH_CFG) begin : g_cfg_check
    $error("fc_hwacc_tcdm_mux parameters differ from fc_hwacc_pkg configuration");
  end

  port_idx_t rr_q;
  port_idx_t lock_idx_q;
  logic      lock_q;
  logic      err_q;
  port_idx_t winner;
  port_idx_t head;
  tcdm_req_t win_req;
  logic      fifo_full;
  logic      fifo_empty;
  logic      gnt;
  logic      pop;

  // Winner: first requester at or after rr_q; a stalled request keeps its port.
  always_comb begin
    logic found;
    int   k;
    winner = rr_q;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      k = int'(rr_q) + i;
      if (k >= N_PORTS) k = k - N_PORTS;
      if (!found && s_req_i[k]) begin
        winner = port_idx_t'(k);
        found  = 1'b1;
      end
    end
    if (lock_q) winner = lock_idx_q;
  end

  always_comb begin
    win_req.add   = s_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
    win_req.wen   = s_wen_i[winner];
    win_req.be    = s_be_i[winner*BE_WIDTH +: BE_WIDTH];
    win_req.wdata = s_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
  end

  assign m_req_o   = (|s_req_i) & ~fifo_full;
  assign m_add_o   = win_req.add;
  assign m_wen_o   = win_req.wen;
  assign m_be_o    = win_req.be;
  assign m_wdata_o = win_req.wdata;
  assign gnt       = m_req_o & m_gnt_i;
  assign pop       = m_r_valid_i & ~fifo_empty;
  assign err_o     = err_q;

  always_comb begin
    s_gnt_o         = '0;
    s_gnt_o[winner] = gnt;
  end

  always_comb begin
    s_r_valid_o = '0;
    s_r_rdata_o = '0;
    if (pop) begin
      s_r_valid_o[head]                          = 1'b1;
      s_r_rdata_o[head*DATA_WIDTH +: DATA_WIDTH] = m_r_rdata_i;
    end
  end

  hwacc_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (gnt) rr_q <= next_idx(winner);
      lock_q <= m_req_o & ~m_gnt_i;
      if (m_req_o && !m_gnt_i) lock_idx_q <= winner;
      if (m_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  a_no_gnt_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_full |-> (s_gnt_o == '0));
  a_onehot_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(s_gnt_o));
  a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> s_req_i[lock_idx_q]);

endmodule
